// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first, DW+1 cycles accept-to-result.
// Single operation in flight; the result is held while out_ready stays low, and a zero divisor short-circuits to DONE.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = $clog2(DW + 1);
    localparam int RW = VW + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rmdr_q, rmdr_d;
    logic          dbz_q, dbz_d;

    logic [RW:0]   trial;
    logic [RW:0]   dvs_ext;
    logic          fits;

    always_comb begin
        trial   = {rem_q, dvd_q[DW-1]};
        dvs_ext = {2'b00, dvs_q};
        fits    = (trial >= dvs_ext);
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rmdr_d  = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CW'(DW);
                    end
                end
            end
            CALC: begin
                // Keep the difference when the divisor fits, otherwise restore the shifted remainder.
                rem_d = fits ? RW'(trial - dvs_ext) : RW'(trial);
                dvd_d = (dvd_q << 1) | DW'(fits);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = dvd_d;
                    rmdr_d  = rem_d[VW-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rmdr_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed boundary cases, backpressure, mid-op reset, then every operand pair.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    wire           in_ready;
    wire           out_valid;
    wire           div_by_zero;
    wire  [DW-1:0] quotient;
    wire  [VW-1:0] remainder;

    int checks = 0;
    int failures = 0;
    int accepted = 0;
    int results = 0;

    always #5 clk = ~clk;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) results <= results + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones quotient and a flag.
    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << DW) - 1; r = 0; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Called at a negedge; returns the number of negedges from the accept edge to out_valid.
    task automatic send(input int a, input int b, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        accepted++;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    // Called at the negedge where out_valid was first seen; stalls, then consumes.
    task automatic collect(input int a, input int b, input int lat, input int stall);
        int q, r, z;
        model(a, b, q, r, z);
        check("latency", 32'(lat), (z != 0) ? 1 : DW + 1);
        check("out_valid", 32'(out_valid), 1);
        check("quotient", 32'(quotient), 32'(q));
        check("remainder", 32'(remainder), 32'(r));
        check("div_by_zero", 32'(div_by_zero), 32'(z));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_quotient", 32'(quotient), 32'(q));
            check("stall_remainder", 32'(remainder), 32'(r));
            check("stall_div_by_zero", 32'(div_by_zero), 32'(z));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_ack_out_valid", 32'(out_valid), 0);
        check("post_ack_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int da [8] = '{200, 255, 7, 0, 255, 100, 9, 50};
        int db [8] = '{13, 1, 9, 5, 15, 0, 3, 7};
        int ds [8] = '{0, 1, 0, 2, 0, 1, 0, 5};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_quotient", 32'(quotient), 0);
        check("reset_remainder", 32'(remainder), 0);
        check("reset_div_by_zero", 32'(div_by_zero), 0);

        for (int i = 0; i < 8; i++) begin
            send(da[i], db[i], lat);
            collect(da[i], db[i], lat, ds[i]);
        end

        // Abort 123/4 three cycles into the calculation.
        in_valid = 1'b1;
        dividend = DW'(123);
        divisor  = VW'(4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_quotient", 32'(quotient), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_div_by_zero", 32'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_result", 32'(out_valid), 0);
        send(123, 4, lat);
        collect(123, 4, lat, 0);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(a, b, lat);
                collect(a, b, lat, int'($urandom_range(0, 3)));
            end
        end

        repeat (2) @(negedge clk);
        check("result_count", 32'(results), 32'(accepted));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
